uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
- Serial-to-parallel UART receiver (8N1, LSB first). Recovers bytes sent by the board-side UART transmitter into the ALU path.
- Sits between the `rx_i` pin (or a bench TX model) and the ALU command parser.
- Presents each received byte on a valid/ready interface.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Must be at least 4.
- SYNC_STAGES, 2, depth of the input synchronizer flops. Must be at least 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous serial line; idles high.
- data_o  output  8  received byte; stable while valid_o=1.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o when valid_o & ready_i.
- busy_o  output  1  a frame is in progress (state is not IDLE/WAIT_IDLE).
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: a new byte was dropped because the previous one was unconsumed.

Behaviour:
- Reset values:
  - data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - All synchronizer flops=1.
  - Bit counter=0, cycle counter=0, state=WAIT_IDLE.
- Synchronizer: rx_i passes through SYNC_STAGES flops. All sampling uses the synchronized value rx_s, so there is SYNC_STAGES cycles of input latency.
- States: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE:
  - Stay until rx_s=1 for one cycle, then go to IDLE.
  - Prevents a false start after reset, or after a frame error, while the line is low.
- IDLE: rx_s=0 -> START, cycle counter cleared.
- START:
  - At cycle counter = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - If 0 -> DATA, counters cleared.
  - If 1 -> glitch; go to IDLE with no flag.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit [bit_cnt], LSB first.
  - After bit 7 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s (mid stop bit).
  - rx_s=1, valid_o=0 or ready_i=1 in the same cycle: load data_o, valid_o=1 -> IDLE.
  - rx_s=1, valid_o=1 and ready_i=0: data_o keeps the old byte, overrun_o=1 for one cycle, new byte discarded -> IDLE.
  - rx_s=0: frame_err_o=1 for one cycle, byte discarded, valid_o/data_o untouched -> WAIT_IDLE.
- Return to IDLE at mid stop bit, so a back-to-back start bit is caught with no lost frames.
- Handshake:
  - valid_o & ready_i clears valid_o next cycle, unless a new byte loads in that same cycle; then valid_o stays 1 with the new data and there is no overrun.
  - ready_i while valid_o=0 has no effect.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT).
  - Bit counter is 3 bits.
  - Neither counter wraps while active; both are cleared on every state change.
- busy_o=1 in START, DATA and STOP.
- reset_i mid-frame: abort immediately to reset values. A frame already in flight is never delivered.
- Pulse outputs never both assert in the same cycle.

Test Plan (CLKS_PER_BIT=16):
- Reset held 3 cycles with rx_i=1, then frame 0xA5, ready_i=1 -> valid_o pulses with data_o=0xA5 about 9.5 bit times (~152 cycles + sync) after the start edge; no flags.
- Frames 0x3C, 0xC3 back-to-back with ready_i=0 until after the second frame -> data_o=0x3C held, overrun_o one pulse at the second stop, valid_o stays 1; after ready_i, valid_o=0.
- Frame 0x55 with stop bit driven 0, then line held low 40 cycles, then high -> frame_err_o one pulse, valid_o stays 0, no new start detected until rx_i returns high.
- rx_i low pulse of 5 cycles in IDLE -> START aborts at mid-bit, busy_o drops, no valid_o and no flags.
- reset_i asserted during DATA bit 4 of 0xFF, released while rx_i=1 -> all outputs 0; the next frame 0x01 is received correctly.
- Frames 0x00 and 0xFF, ready_i tied 1, consumed in the same cycle the second byte loads -> both delivered in order, overrun_o never asserts.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver: deserialises rx_i (LSB first) into bytes on a valid/ready port, flagging framing errors and overruns.
// Latency: SYNC_STAGES cycles of input sync, then valid_o rises at the mid-point of the stop bit (~9.5 bit times after the start edge).
// Backpressure: one-byte holding register; a byte completing while the previous one is unconsumed is dropped and overrun_o pulses.
//
// Ports:
//   clk_i, reset_i     - clock, synchronous active-high reset
//   rx_i               - asynchronous serial line, idles high
//   data_o/valid_o     - received byte, held until valid_o & ready_i
//   ready_i            - consumer accept
//   busy_o             - frame in progress (START/DATA/STOP)
//   frame_err_o        - one-cycle pulse: stop bit sampled low
//   overrun_o          - one-cycle pulse: completed byte discarded, holding register was full
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   fe_q, fe_d;
    logic                   ov_q, ov_d;
    logic                   rx_s;

    // Oldest synchronizer stage is the only view of the line the FSM ever uses.
    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        // A pending byte is retired by the handshake unless a new one loads below.
        valid_d = valid_q & ~ready_i;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        case (state_q)
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Re-check the line mid start bit; a high here was a glitch.
                if (cyc_q == HALF_M1) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_DATA: begin
                if (cyc_q == FULL_M1) begin
                    shift_d[bit_q] = rx_s;
                    cyc_d          = '0;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_STOP: begin
                if (cyc_q == FULL_M1) begin
                    if (rx_s) begin
                        if (!valid_q || ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        // Every state entry starts both counters from zero.
        if (state_d != state_q) begin
            cyc_d = '0;
            bit_d = '0;
        end

        busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_WAIT_IDLE;
            sync_q  <= '1;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;

endmodule
